sramc_write_combiner: RTL and testbench
=======================================

SRAMC_WRITE_COMBINER -- requirements
Module: sramc_write_combiner

Interface
REQ-001 SHALL have parameter SRAMC_W, default 1024, SRAM data width.
REQ-002 SHALL have parameter ADRC_W, default 11, SRAM address width.
REQ-003 SHALL have parameter SRAMC_N, default 32, mask elements; element width EW = SRAMC_W/SRAMC_N.
REQ-004 SHALL have parameter IDLE_FLUSH, default 16, number of idle cycles before auto-flush.
REQ-005 SHALL have ports:
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_sramc_wdata_q  in  SRAMC_W  quantized write data from the quantization stage.
- i_sramc_addr_q  in  ADRC_W  word address.
- i_sramc_wren_q  in  1  write request.
- i_sramc_wmask_q  in  [0:SRAMC_N-1]  element mask; bit i selects data[EW*i +: EW].
- i_sramc_rden_q  in  1  read request.
- i_flush  in  1  force buffer drain.
- o_sramc_wdata  out  SRAMC_W  SRAM write data.
- o_sramc_addr  out  ADRC_W  SRAM address.
- o_sramc_wren  out  1  SRAM write strobe.
- o_sramc_wmask  out  [0:SRAMC_N-1]  SRAM element mask.
- o_sramc_rden  out  1  SRAM read strobe.
- o_ready  out  1  input accepted this cycle.
- o_err  out  1  sticky protocol/drop error.

Function
REQ-006 SHALL merge partial-mask writes to the same word address into one line buffer (data, mask, addr, valid) and issue one SRAM write per line.
REQ-007 SHALL register all SRAM outputs; the SRAM command appears the cycle after its triggering event. Outside command cycles, wren, rden, wmask and wdata SHALL be 0, while addr SHALL hold its last value.
REQ-008 SHALL use FSM states EMPTY, HOLD and RD_PEND.
REQ-009 In EMPTY, an accepted write with a nonzero mask SHALL load the buffer (masked elements only) and go to HOLD; with a full mask it SHALL emit directly and stay EMPTY.
REQ-010 In HOLD, a write to the buffered addr SHALL overwrite the masked elements and OR the mask; if the result is all ones, it SHALL emit and go to EMPTY.
REQ-011 In HOLD, a write to a different addr SHALL emit the old line and load the new one, applying the REQ-009 full-mask rule.
REQ-012 A write with an all-zero mask SHALL be a no-op.
REQ-013 A read in EMPTY SHALL emit rden with the read addr the next cycle.
REQ-014 A read in HOLD SHALL emit the buffered write at T+1, then the read at T+2 via RD_PEND, and finally enter EMPTY.
REQ-015 o_ready SHALL be 0 only in RD_PEND; any request presented while o_ready=0 SHALL be dropped and SHALL set o_err.
REQ-016 Simultaneous wren and rden SHALL set o_err and be processed as a write only.
REQ-017 i_flush in HOLD SHALL emit the line and go to EMPTY; if a write arrives in the same cycle, the REQ-011 rule SHALL apply instead.
REQ-018 An idle counter SHALL clear on every accepted write and increment each HOLD cycle without one; reaching IDLE_FLUSH-1 SHALL trigger a flush.
REQ-019 An emitted mask SHALL equal the accumulated mask; unmasked element data SHALL be 0.

Reset
REQ-020 i_rst SHALL clear the buffer, idle counter, o_err and all outputs to 0, set FSM to EMPTY and set o_ready=1 on the next edge.
REQ-021 Reset mid-operation SHALL discard buffered or pending data without emitting it.

Structure
REQ-022 The FSM state enum and the default widths SHALL reside in the shared sauria_core package.
REQ-023 The line buffer (merge, mask OR, full detect) SHALL be one sub-module, wc_line_buf; the FSM and output registers SHALL be in the top.

Verification
REQ-024 Writes to addr 5 with masks 0x0000000F, 0x000000F0, ..., 0xF0000000 (eight beats) -> a single write at addr 5 with mask 0xFFFFFFFF and merged data, one cycle after the 8th beat.
REQ-025 A write to addr 3 with mask 0x3, then addr 4 with mask 0xFFFFFFFF -> a write to addr 3 (mask 0x3), then a write to addr 4 on the next cycle.
REQ-026 A write to addr 7 with mask 0x3, then a read of addr 7 -> the write at T+1, rden at T+2, o_ready=0 at T+1; a write injected at T+1 sets o_err.
REQ-027 A write to addr 9 with mask 0x1, then 16 idle cycles -> an auto-flush write to addr 9 with mask 0x1.
REQ-028 wren and rden high together -> the write is processed and o_err=1; a reset asserted in HOLD -> no write is emitted and all outputs are 0.

Source files
------------

// File: rtl/sauria_core_pkg.sv
// Shared definitions for the sauria core SRAM path: default widths and the
// write-combiner FSM state encoding.
package sauria_core_pkg;

    localparam int SRAMC_W_DEF    = 1024;
    localparam int ADRC_W_DEF     = 11;
    localparam int SRAMC_N_DEF    = 32;
    localparam int IDLE_FLUSH_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HOLD    = 2'd1,
        RD_PEND = 2'd2
    } wc_state_e;

endpackage

// File: rtl/wc_line_buf.sv
// Single-line merge buffer: holds one partially written SRAM word and offers
// the combinational merge of an incoming write against it.
module wc_line_buf
    import sauria_core_pkg::*;
#(
    parameter int SRAMC_W = SRAMC_W_DEF,
    parameter int ADRC_W  = ADRC_W_DEF,
    parameter int SRAMC_N = SRAMC_N_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_merge,
    input  logic               i_clear,
    input  logic [SRAMC_W-1:0] i_data,
    input  logic [ADRC_W-1:0]  i_addr,
    input  logic [0:SRAMC_N-1] i_mask,
    output logic [SRAMC_W-1:0] o_data,
    output logic [ADRC_W-1:0]  o_addr,
    output logic [0:SRAMC_N-1] o_mask,
    output logic               o_full,
    output logic               o_hit,
    output logic [SRAMC_W-1:0] o_in_data,
    output logic               o_in_full,
    output logic [SRAMC_W-1:0] o_mrg_data,
    output logic [0:SRAMC_N-1] o_mrg_mask,
    output logic               o_mrg_full
);

    localparam int EW = SRAMC_W / SRAMC_N;

    logic [SRAMC_W-1:0] data_q, data_d;
    logic [ADRC_W-1:0]  addr_q, addr_d;
    logic [0:SRAMC_N-1] mask_q, mask_d;
    logic               valid_q, valid_d;
    logic [SRAMC_W-1:0] in_bits;

    function automatic logic [SRAMC_W-1:0] expand(input logic [0:SRAMC_N-1] m);
        logic [SRAMC_W-1:0] r;
        r = '0;
        for (int i = 0; i < SRAMC_N; i++) r[EW*i +: EW] = {EW{m[i]}};
        return r;
    endfunction

    // Unmasked elements are forced to zero so the buffer never carries stale data.
    assign in_bits    = expand(i_mask);
    assign o_in_data  = i_data & in_bits;
    assign o_in_full  = &i_mask;
    assign o_mrg_data = (data_q & ~in_bits) | o_in_data;
    assign o_mrg_mask = mask_q | i_mask;
    assign o_mrg_full = &o_mrg_mask;
    assign o_hit      = valid_q && (addr_q == i_addr);
    assign o_full     = &mask_q;
    assign o_data     = data_q;
    assign o_addr     = addr_q;
    assign o_mask     = mask_q;

    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        if (i_clear) begin
            data_d  = '0;
            addr_d  = '0;
            mask_d  = '0;
            valid_d = 1'b0;
        end else if (i_load) begin
            data_d  = o_in_data;
            addr_d  = i_addr;
            mask_d  = i_mask;
            valid_d = 1'b1;
        end else if (i_merge) begin
            data_d  = o_mrg_data;
            mask_d  = o_mrg_mask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/sramc_write_combiner.sv
// Write combiner in front of the SRAM: merges partial-mask writes to one word
// into a single SRAM write and orders reads behind any buffered line.
module sramc_write_combiner
    import sauria_core_pkg::*;
#(
    parameter int SRAMC_W    = SRAMC_W_DEF,
    parameter int ADRC_W     = ADRC_W_DEF,
    parameter int SRAMC_N    = SRAMC_N_DEF,
    parameter int IDLE_FLUSH = IDLE_FLUSH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SRAMC_W-1:0] i_sramc_wdata_q,
    input  logic [ADRC_W-1:0]  i_sramc_addr_q,
    input  logic               i_sramc_wren_q,
    input  logic [0:SRAMC_N-1] i_sramc_wmask_q,
    input  logic               i_sramc_rden_q,
    input  logic               i_flush,
    output logic [SRAMC_W-1:0] o_sramc_wdata,
    output logic [ADRC_W-1:0]  o_sramc_addr,
    output logic               o_sramc_wren,
    output logic [0:SRAMC_N-1] o_sramc_wmask,
    output logic               o_sramc_rden,
    output logic               o_ready,
    output logic               o_err
);

    localparam int IW = $clog2(IDLE_FLUSH) + 1;

    wc_state_e          state_q, state_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic               err_q, err_d;
    logic [ADRC_W-1:0]  rd_addr_q, rd_addr_d;
    logic [SRAMC_W-1:0] wdata_q, wdata_d;
    logic [ADRC_W-1:0]  addr_q, addr_d;
    logic [0:SRAMC_N-1] wmask_q, wmask_d;
    logic               wren_q, wren_d, rden_q, rden_d;

    logic               ready, wr_acc, wr_live, rd_acc;
    logic               lb_load, lb_merge, lb_clear;
    logic [SRAMC_W-1:0] lb_data, lb_in_data, lb_mrg_data;
    logic [ADRC_W-1:0]  lb_addr;
    logic [0:SRAMC_N-1] lb_mask, lb_mrg_mask;
    logic               lb_full, lb_hit, lb_in_full, lb_mrg_full;

    wc_line_buf #(
        .SRAMC_W (SRAMC_W),
        .ADRC_W  (ADRC_W),
        .SRAMC_N (SRAMC_N)
    ) u_line_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (lb_load),
        .i_merge    (lb_merge),
        .i_clear    (lb_clear),
        .i_data     (i_sramc_wdata_q),
        .i_addr     (i_sramc_addr_q),
        .i_mask     (i_sramc_wmask_q),
        .o_data     (lb_data),
        .o_addr     (lb_addr),
        .o_mask     (lb_mask),
        .o_full     (lb_full),
        .o_hit      (lb_hit),
        .o_in_data  (lb_in_data),
        .o_in_full  (lb_in_full),
        .o_mrg_data (lb_mrg_data),
        .o_mrg_mask (lb_mrg_mask),
        .o_mrg_full (lb_mrg_full)
    );

    assign ready   = (state_q != RD_PEND);
    assign wr_acc  = ready && i_sramc_wren_q;
    assign wr_live = wr_acc && (|i_sramc_wmask_q);
    assign rd_acc  = ready && i_sramc_rden_q && !i_sramc_wren_q;

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        err_d     = err_q;
        rd_addr_d = rd_addr_q;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        wmask_d   = '0;
        wdata_d   = '0;
        addr_d    = addr_q;
        lb_load   = 1'b0;
        lb_merge  = 1'b0;
        lb_clear  = 1'b0;

        if ((!ready && (i_sramc_wren_q || i_sramc_rden_q)) ||
            (ready && i_sramc_wren_q && i_sramc_rden_q))
            err_d = 1'b1;

        case (state_q)
            EMPTY: begin
                idle_d = '0;
                if (wr_live) begin
                    if (lb_in_full) begin
                        wren_d  = 1'b1;
                        addr_d  = i_sramc_addr_q;
                        wmask_d = i_sramc_wmask_q;
                        wdata_d = lb_in_data;
                    end else begin
                        lb_load = 1'b1;
                        state_d = HOLD;
                    end
                end else if (rd_acc) begin
                    rden_d = 1'b1;
                    addr_d = i_sramc_addr_q;
                end
            end
            HOLD: begin
                if (wr_live) begin
                    idle_d = '0;
                    if (lb_hit && !i_flush) begin
                        if (lb_mrg_full) begin
                            wren_d   = 1'b1;
                            addr_d   = lb_addr;
                            wmask_d  = lb_mrg_mask;
                            wdata_d  = lb_mrg_data;
                            lb_clear = 1'b1;
                            state_d  = EMPTY;
                        end else begin
                            lb_merge = 1'b1;
                        end
                    end else begin
                        // A full incoming line stays in HOLD and drains on the next cycle.
                        wren_d  = 1'b1;
                        addr_d  = lb_addr;
                        wmask_d = lb_mask;
                        wdata_d = lb_data;
                        lb_load = 1'b1;
                    end
                end else if (rd_acc) begin
                    wren_d    = 1'b1;
                    addr_d    = lb_addr;
                    wmask_d   = lb_mask;
                    wdata_d   = lb_data;
                    lb_clear  = 1'b1;
                    rd_addr_d = i_sramc_addr_q;
                    idle_d    = '0;
                    state_d   = RD_PEND;
                end else if (i_flush || lb_full ||
                             (!wr_acc && idle_q == IW'(IDLE_FLUSH - 1))) begin
                    wren_d   = 1'b1;
                    addr_d   = lb_addr;
                    wmask_d  = lb_mask;
                    wdata_d  = lb_data;
                    lb_clear = 1'b1;
                    idle_d   = '0;
                    state_d  = EMPTY;
                end else begin
                    idle_d = wr_acc ? '0 : idle_q + IW'(1);
                end
            end
            RD_PEND: begin
                rden_d  = 1'b1;
                addr_d  = rd_addr_q;
                idle_d  = '0;
                state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= EMPTY;
            idle_q    <= '0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            wmask_q   <= '0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
            rd_addr_q <= rd_addr_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
        end
    end

    assign o_sramc_wdata = wdata_q;
    assign o_sramc_addr  = addr_q;
    assign o_sramc_wren  = wren_q;
    assign o_sramc_wmask = wmask_q;
    assign o_sramc_rden  = rden_q;
    assign o_ready       = ready;
    assign o_err         = err_q;

endmodule

// File: tb/tb_sramc_write_combiner.sv
// Directed bench for sramc_write_combiner: merge, eviction, read ordering,
// idle flush, error and reset behaviour.
module tb_sramc_write_combiner;

    localparam int W  = 1024;
    localparam int AW = 11;
    localparam int N  = 32;
    localparam int EW = W / N;
    localparam int IF = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [W-1:0]  i_sramc_wdata_q;
    logic [AW-1:0] i_sramc_addr_q;
    logic          i_sramc_wren_q;
    logic [0:N-1]  i_sramc_wmask_q;
    logic          i_sramc_rden_q;
    logic          i_flush;
    logic [W-1:0]  o_sramc_wdata;
    logic [AW-1:0] o_sramc_addr;
    logic          o_sramc_wren;
    logic [0:N-1]  o_sramc_wmask;
    logic          o_sramc_rden;
    logic          o_ready;
    logic          o_err;

    int n_tests = 0;
    int n_fail  = 0;

    sramc_write_combiner #(
        .SRAMC_W    (W),
        .ADRC_W     (AW),
        .SRAMC_N    (N),
        .IDLE_FLUSH (IF)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_sramc_wdata_q (i_sramc_wdata_q),
        .i_sramc_addr_q  (i_sramc_addr_q),
        .i_sramc_wren_q  (i_sramc_wren_q),
        .i_sramc_wmask_q (i_sramc_wmask_q),
        .i_sramc_rden_q  (i_sramc_rden_q),
        .i_flush         (i_flush),
        .o_sramc_wdata   (o_sramc_wdata),
        .o_sramc_addr    (o_sramc_addr),
        .o_sramc_wren    (o_sramc_wren),
        .o_sramc_wmask   (o_sramc_wmask),
        .o_sramc_rden    (o_sramc_rden),
        .o_ready         (o_ready),
        .o_err           (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] expand(input logic [0:N-1] m);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (m[i]) r[EW*i +: EW] = '1;
        return r;
    endfunction

    // Element i of beat b carries {b+1, i, BEEF} so misplaced elements are visible.
    function automatic logic [W-1:0] mkdata(input int b);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[EW*i +: EW] = {8'(b + 1), 8'(i), 16'hBEEF};
        return r;
    endfunction

    function automatic logic [63:0] dsig(input logic [W-1:0] x);
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < W / 64; k++) s = (s ^ x[64*k +: 64]) * 64'h0000_0100_0000_01B3;
        return s;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in();
        i_sramc_wdata_q = '0;
        i_sramc_addr_q  = '0;
        i_sramc_wren_q  = 1'b0;
        i_sramc_wmask_q = '0;
        i_sramc_rden_q  = 1'b0;
        i_flush         = 1'b0;
    endtask

    task automatic wr_in(input int a, input logic [31:0] m, input logic [W-1:0] d);
        i_sramc_wdata_q = d;
        i_sramc_addr_q  = AW'(a);
        i_sramc_wren_q  = 1'b1;
        i_sramc_wmask_q = m;
        i_sramc_rden_q  = 1'b0;
        i_flush         = 1'b0;
    endtask

    task automatic rd_in(input int a);
        idle_in();
        i_sramc_addr_q = AW'(a);
        i_sramc_rden_q = 1'b1;
    endtask

    task automatic do_reset();
        idle_in();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic count_wren(input int cycles, output int bad);
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (o_sramc_wren) bad++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [0:N-1] m;
        logic [W-1:0] exp_d;
        int bad;

        idle_in();
        i_rst = 1'b1;
        tick();
        tick();
        check("rst_wren",  64'(o_sramc_wren), 64'h0);
        check("rst_rden",  64'(o_sramc_rden), 64'h0);
        check("rst_wmask", 64'(o_sramc_wmask), 64'h0);
        check("rst_addr",  64'(o_sramc_addr), 64'h0);
        check("rst_wdata", dsig(o_sramc_wdata), 64'h0);
        check("rst_ready", 64'(o_ready), 64'h1);
        check("rst_err",   64'(o_err), 64'h0);
        i_rst = 1'b0;

        // Eight nibble-mask beats to addr 5 merge into one full write.
        exp_d = '0;
        for (int b = 0; b < 8; b++) begin
            m = 32'hF << (4 * b);
            exp_d = (exp_d & ~expand(m)) | (mkdata(b) & expand(m));
            wr_in(5, m, mkdata(b));
            tick();
            if (b < 7) check("merge_no_early_wren", 64'(o_sramc_wren), 64'h0);
        end
        check("merge_wren",  64'(o_sramc_wren), 64'h1);
        check("merge_addr",  64'(o_sramc_addr), 64'd5);
        check("merge_wmask", 64'(o_sramc_wmask), 64'hFFFF_FFFF);
        check("merge_wdata", dsig(o_sramc_wdata), dsig(exp_d));
        idle_in();
        tick();
        check("post_cmd_wren",  64'(o_sramc_wren), 64'h0);
        check("post_cmd_wmask", 64'(o_sramc_wmask), 64'h0);
        check("post_cmd_wdata", dsig(o_sramc_wdata), 64'h0);
        check("post_cmd_addr_hold", 64'(o_sramc_addr), 64'd5);

        // Partial line at 3 evicted by a full write to 4, which follows a cycle later.
        wr_in(3, 32'h3, mkdata(10));
        tick();
        check("evict_hold_wren", 64'(o_sramc_wren), 64'h0);
        wr_in(4, 32'hFFFF_FFFF, mkdata(11));
        tick();
        m = 32'h3;
        check("evict_old_wren",  64'(o_sramc_wren), 64'h1);
        check("evict_old_addr",  64'(o_sramc_addr), 64'd3);
        check("evict_old_wmask", 64'(o_sramc_wmask), 64'h3);
        check("evict_old_wdata", dsig(o_sramc_wdata), dsig(mkdata(10) & expand(m)));
        idle_in();
        tick();
        check("evict_new_wren",  64'(o_sramc_wren), 64'h1);
        check("evict_new_addr",  64'(o_sramc_addr), 64'd4);
        check("evict_new_wmask", 64'(o_sramc_wmask), 64'hFFFF_FFFF);
        check("evict_new_wdata", dsig(o_sramc_wdata), dsig(mkdata(11)));
        tick();
        check("evict_done_wren", 64'(o_sramc_wren), 64'h0);

        // Full-mask write while empty goes straight out.
        wr_in(6, 32'hFFFF_FFFF, mkdata(12));
        tick();
        check("direct_wren", 64'(o_sramc_wren), 64'h1);
        check("direct_addr", 64'(o_sramc_addr), 64'd6);
        idle_in();
        tick();
        check("direct_done_wren", 64'(o_sramc_wren), 64'h0);

        // Read behind a buffered line; a write during RD_PEND is dropped.
        wr_in(7, 32'h3, mkdata(13));
        tick();
        rd_in(7);
        tick();
        check("rdh_wren",  64'(o_sramc_wren), 64'h1);
        check("rdh_addr",  64'(o_sramc_addr), 64'd7);
        check("rdh_wmask", 64'(o_sramc_wmask), 64'h3);
        check("rdh_rden0", 64'(o_sramc_rden), 64'h0);
        check("rdh_ready0", 64'(o_ready), 64'h0);
        wr_in(8, 32'h1, mkdata(14));
        tick();
        check("rdh_rden",  64'(o_sramc_rden), 64'h1);
        check("rdh_raddr", 64'(o_sramc_addr), 64'd7);
        check("rdh_wren1", 64'(o_sramc_wren), 64'h0);
        check("rdh_err",   64'(o_err), 64'h1);
        check("rdh_ready1", 64'(o_ready), 64'h1);
        idle_in();
        count_wren(20, bad);
        check("drop_no_emit", 64'(bad), 64'h0);
        check("err_sticky", 64'(o_err), 64'h1);

        do_reset();
        check("err_cleared", 64'(o_err), 64'h0);

        // Read while empty.
        rd_in(20);
        tick();
        check("rde_rden", 64'(o_sramc_rden), 64'h1);
        check("rde_addr", 64'(o_sramc_addr), 64'd20);
        check("rde_wren", 64'(o_sramc_wren), 64'h0);
        idle_in();
        tick();
        check("rde_done_rden", 64'(o_sramc_rden), 64'h0);
        check("rde_addr_hold", 64'(o_sramc_addr), 64'd20);

        // Zero-mask write is a no-op and never flushes.
        wr_in(13, 32'h0, mkdata(15));
        tick();
        idle_in();
        count_wren(20, bad);
        check("zero_mask_noop", 64'(bad), 64'h0);

        // Explicit flush drains a held line.
        wr_in(12, 32'h1, mkdata(16));
        tick();
        idle_in();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        m = 32'h1;
        check("flush_wren",  64'(o_sramc_wren), 64'h1);
        check("flush_addr",  64'(o_sramc_addr), 64'd12);
        check("flush_wmask", 64'(o_sramc_wmask), 64'h1);
        check("flush_wdata", dsig(o_sramc_wdata), dsig(mkdata(16) & expand(m)));

        // Idle auto-flush after IDLE_FLUSH quiet cycles.
        wr_in(9, 32'h1, mkdata(17));
        tick();
        idle_in();
        count_wren(IF - 1, bad);
        check("idle_no_early", 64'(bad), 64'h0);
        tick();
        check("idle_wren",  64'(o_sramc_wren), 64'h1);
        check("idle_addr",  64'(o_sramc_addr), 64'd9);
        check("idle_wmask", 64'(o_sramc_wmask), 64'h1);
        check("idle_wdata", dsig(o_sramc_wdata), dsig(mkdata(17) & expand(m)));

        // Simultaneous write and read: write only, error flagged.
        wr_in(10, 32'hFFFF_FFFF, mkdata(18));
        i_sramc_rden_q = 1'b1;
        tick();
        check("wrrd_wren", 64'(o_sramc_wren), 64'h1);
        check("wrrd_rden", 64'(o_sramc_rden), 64'h0);
        check("wrrd_addr", 64'(o_sramc_addr), 64'd10);
        check("wrrd_err",  64'(o_err), 64'h1);

        // Reset while holding a line discards it.
        do_reset();
        wr_in(6, 32'hFFFF_FFFF, mkdata(19));
        tick();
        wr_in(11, 32'h1, mkdata(20));
        tick();
        idle_in();
        i_rst = 1'b1;
        tick();
        check("hrst_wren",  64'(o_sramc_wren), 64'h0);
        check("hrst_rden",  64'(o_sramc_rden), 64'h0);
        check("hrst_addr",  64'(o_sramc_addr), 64'h0);
        check("hrst_wmask", 64'(o_sramc_wmask), 64'h0);
        check("hrst_wdata", dsig(o_sramc_wdata), 64'h0);
        check("hrst_ready", 64'(o_ready), 64'h1);
        i_rst = 1'b0;
        count_wren(IF + 4, bad);
        check("hrst_no_emit", 64'(bad), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
